// File: rtl/reg_file_sweep.sv
// reg_file_sweep: WIDTH x DEPTH register file with one write port and two tri-state read ports.
// Reads see a same-cycle write (write-before-read).
// A sweep FSM zeroes every entry after reset or when clr is raised.
// Optional macro REGFILE_ZERO_REG_EN makes entry 0 a hardwired zero.
module reg_file_sweep #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              WriteReg,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [WIDTH-1:0]  D,
  input  logic              ReadEnable1,
  input  logic [ADDR_W-1:0] ReadAddr1,
  output logic [WIDTH-1:0]  Bitline1,
  input  logic              ReadEnable2,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [WIDTH-1:0]  Bitline2,
  output logic              ready
);
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
  typedef enum logic {INIT, READY} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              wr_hit, wr_en;
  // An address is usable when it names a real entry and is not the hardwired zero entry.
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !(ZR && a == '0);
  endfunction
  // Read value before tri-stating: zero while sweeping or for unusable addresses, otherwise bypass or storage.
  function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a);
    return (state_q == READY && ok(a)) ? ((wr_hit && WriteAddr == a) ? D : mem_q[a]) : '0;
  endfunction
  assign wr_hit   = state_q == READY && WriteReg && ok(WriteAddr);
  assign wr_en    = wr_hit && rst && !clr;
  assign ready    = state_q == READY;
  assign Bitline1 = ReadEnable1 ? rd(ReadAddr1) : 'z;
  assign Bitline2 = ReadEnable2 ? rd(ReadAddr2) : 'z;
  // Sweep walks idx through every entry, then enters READY; clr in READY restarts the sweep.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == INIT) begin
      state_d = idx_q == LAST ? READY : INIT;
      idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
    end else if (clr) begin
      state_d = INIT;
      idx_d   = '0;
    end
  end
  // FSM and sweep index registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
  // Storage has no reset; the sweep clears it, and user writes land only in READY.
  always_ff @(posedge clk) begin
    if (rst && state_q == INIT) mem_q[idx_q] <= '0;
    else if (wr_en) mem_q[WriteAddr] <= D;
  end
endmodule

// File: tb/tb_reg_file_sweep.sv
// tb_reg_file_sweep: checks DEPTH=16 and DEPTH=12 register files, both driven by the same stimulus, against a reference model.
module tb_reg_file_sweep;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, clr, we, re1, re2;
  logic [3:0] wa, ra1, ra2;
  logic [15:0] d;
  logic [15:0] a1, a2, b1, b2;
  logic ar, br;
  int total = 0, bad = 0;
  int dep [2] = '{16, 12};
  logic [15:0] mem [2][16];
  bit init [2] = '{1'b1, 1'b1};
  int cnt [2] = '{0, 0};
`ifdef REGFILE_ZERO_REG_EN
  bit zr = 1'b1;
`else
  bit zr = 1'b0;
`endif
  reg_file_sweep #(.WIDTH(16), .DEPTH(16)) u16 (
    .clk(clk), .rst(rst), .clr(clr), .WriteReg(we), .WriteAddr(wa), .D(d),
    .ReadEnable1(re1), .ReadAddr1(ra1), .Bitline1(a1),
    .ReadEnable2(re2), .ReadAddr2(ra2), .Bitline2(a2), .ready(ar));
  reg_file_sweep #(.WIDTH(16), .DEPTH(12)) u12 (
    .clk(clk), .rst(rst), .clr(clr), .WriteReg(we), .WriteAddr(wa), .D(d),
    .ReadEnable1(re1), .ReadAddr1(ra1), .Bitline1(b1),
    .ReadEnable2(re2), .ReadAddr2(ra2), .Bitline2(b2), .ready(br));
  function automatic logic [15:0] exp_rd(int k, logic en, logic [3:0] a);
    if (!en) return 'z;
    if (init[k] || int'(a) >= dep[k] || (zr && a == 4'd0)) return 16'h0000;
    if (we && wa == a) return d;
    return mem[k][a];
  endfunction
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        init[k] = 1'b1;
        cnt[k]  = 0;
      end else if (init[k]) begin
        mem[k][cnt[k]] = 16'h0000;
        cnt[k]++;
        if (cnt[k] == dep[k]) init[k] = 1'b0;
      end else if (clr) begin
        init[k] = 1'b1;
        cnt[k]  = 0;
      end else if (we && int'(wa) < dep[k] && !(zr && wa == 4'd0)) begin
        mem[k][wa] = d;
      end
    end
    #1;
  endtask
  task automatic chk(string tag);
    logic [15:0] o1, o2, e1, e2;
    logic r;
    #1;
    for (int k = 0; k < 2; k++) begin
      o1 = k == 0 ? a1 : b1;
      o2 = k == 0 ? a2 : b2;
      r  = k == 0 ? ar : br;
      e1 = exp_rd(k, re1, ra1);
      e2 = exp_rd(k, re2, ra2);
      total++;
      assert (r === !init[k]) else begin bad++; $error("FAIL %s ready d%0d got=%b want=%b", tag, dep[k], r, !init[k]); end
      total++;
      assert (o1 === e1) else begin bad++; $error("FAIL %s bl1 d%0d a=%0d got=%h want=%h", tag, dep[k], ra1, o1, e1); end
      total++;
      assert (o2 === e2) else begin bad++; $error("FAIL %s bl2 d%0d a=%0d got=%h want=%h", tag, dep[k], ra2, o2, e2); end
    end
  endtask
  initial begin
    rst = 1'b0; clr = 1'b0; we = 1'b0; re1 = 1'b1; re2 = 1'b1;
    wa = 4'd0; ra1 = 4'd0; ra2 = 4'd0; d = 16'h0000;
    repeat (3) step();
    chk("reset");
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i); ra2 = 4'(15 - i);
      chk("sweep");
      step();
    end
    chk("swept");
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i); ra2 = 4'(i);
      chk("zeroed");
    end
    we = 1'b1; wa = 4'd3; d = 16'hA5A5; ra1 = 4'd0;
    chk("wr_pre");
    step();
    we = 1'b0; ra1 = 4'd3;
    chk("wr_rd");
    re1 = 1'b0;
    chk("tristate");
    re1 = 1'b1;
    we = 1'b1; wa = 4'd7; d = 16'h1234; ra1 = 4'd7; ra2 = 4'd7;
    chk("bypass");
    step();
    we = 1'b0;
    chk("bypass_held");
    we = 1'b1; wa = 4'd2; d = 16'hBEEF;
    step();
    clr = 1'b1; wa = 4'd5; d = 16'h5555; ra1 = 4'd2; ra2 = 4'd5;
    chk("clr_cyc");
    step();
    clr = 1'b0; we = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk("clr_sweep");
      step();
    end
    chk("clr_done");
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (6) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk("mid_rst");
      step();
    end
    we = 1'b1; wa = 4'd13; d = 16'hC3C3; ra1 = 4'd13; ra2 = 4'd1;
    chk("oor_cyc");
    step();
    we = 1'b0; ra2 = 4'd13;
    chk("oor_after");
    we = 1'b1; wa = 4'd0; d = 16'hFFFF; ra1 = 4'd0; ra2 = 4'd0;
    chk("addr0_cyc");
    step();
    we = 1'b0;
    chk("addr0_after");
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 99) != 0;
      clr = $urandom_range(0, 59) == 0;
      we  = $urandom_range(0, 2) != 0;
      wa  = 4'($urandom);
      ra1 = $urandom_range(0, 3) == 0 ? wa : 4'($urandom);
      ra2 = $urandom_range(0, 3) == 0 ? wa : 4'($urandom);
      re1 = $urandom_range(0, 7) != 0;
      re2 = $urandom_range(0, 7) != 0;
      d   = 16'($urandom);
      chk("random");
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
